// File: rtl/shift_chain_ctrl.sv
// Parallel-to-serial sequencer for an external shift chain: shifts a loaded word out
// MSB-first under a divided strobe while capturing the returning bits into a parallel word.
module shift_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic             shift_out,
  input  logic             shift_in,
  output logic             shift_en,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;

  assign strobe = (state == SHIFT) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Every output is a decode of state and registers; handshake inputs only steer next state.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cap_valid  = 1'b0;
    shift_en   = 1'b0;
    shift_out  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        shift_out = out_reg[WIDTH-1];
        shift_en  = strobe;
        if (strobe && (bit_cnt == BIT_LAST)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        cap_valid = 1'b1;
        if (cap_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shift_in is sampled on the same edge the chain advances, so it is the pre-shift chain bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_reg  <= '0;
      cap_reg  <= '0;
      cap_data <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            out_reg <= load_data;
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (strobe) begin
            out_reg <= {out_reg[WIDTH-2:0], 1'b0};
            cap_reg <= {cap_reg[WIDTH-2:0], shift_in};
            bit_cnt <= bit_cnt + CNT_W'(1);
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) cap_data <= {cap_reg[WIDTH-2:0], shift_in};
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed bench for shift_chain_ctrl: one DIV=1 and one DIV=3 instance, each looped
// through an 8-stage shift-register model of the external chain.
module tb_shift_chain_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] ld1_data, ld3_data, cp1_data, cp3_data;
  logic       ld1_valid, ld1_ready, cp1_valid, cp1_ready;
  logic       ld3_valid, ld3_ready, cp3_valid, cp3_ready;
  logic       so1, si1, en1, busy1;
  logic       so3, si3, en3, busy3;
  logic [7:0] chain1, chain3;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  shift_chain_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (
    .clk(clk), .clr(clr),
    .load_data(ld1_data), .load_valid(ld1_valid), .load_ready(ld1_ready),
    .cap_data(cp1_data), .cap_valid(cp1_valid), .cap_ready(cp1_ready),
    .shift_out(so1), .shift_in(si1), .shift_en(en1), .busy(busy1)
  );

  shift_chain_ctrl #(.WIDTH(8), .DIV(3)) u_dut3 (
    .clk(clk), .clr(clr),
    .load_data(ld3_data), .load_valid(ld3_valid), .load_ready(ld3_ready),
    .cap_data(cp3_data), .cap_valid(cp3_valid), .cap_ready(cp3_ready),
    .shift_out(so3), .shift_in(si3), .shift_en(en3), .busy(busy3)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      chain1 <= '0;
      chain3 <= '0;
    end else begin
      if (en1) chain1 <= {chain1[6:0], so1};
      if (en3) chain3 <= {chain3[6:0], so3};
    end
  end

  assign si1 = chain1[7];
  assign si3 = chain3[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts in the accept cycle; ends in the first cap_valid cycle.
  task automatic xfer1(input logic [7:0] word, input logic [7:0] exp, input bit poke);
    ld1_data  = word;
    ld1_valid = 1'b1;
    chk("x1_ready_c0", ld1_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      ld1_valid = 1'b0;
      ld1_data  = word;
      if (poke && k == 3) begin
        ld1_valid = 1'b1;
        ld1_data  = 8'h11;
      end
      chk("x1_shift_en", en1, 1);
      chk("x1_shift_out", so1, word[8-k]);
      chk("x1_ready_busy", ld1_ready, 0);
      chk("x1_cap_valid_early", cp1_valid, 0);
    end
    tick();
    chk("x1_cap_valid", cp1_valid, 1);
    chk("x1_cap_data", cp1_data, exp);
    chk("x1_done_en", en1, 0);
    chk("x1_done_out", so1, 0);
    chk("x1_done_busy", busy1, 1);
    chk("x1_chain", chain1, word);
  endtask

  task automatic done1();
    cp1_ready = 1'b1;
    chk("h1_ready_in_hs", ld1_ready, 0);
    tick();
    cp1_ready = 1'b0;
    chk("h1_cap_valid_low", cp1_valid, 0);
    chk("h1_ready_after", ld1_ready, 1);
    chk("h1_idle", busy1, 0);
  endtask

  initial begin
    logic [7:0] words [4];
    logic [7:0] caps  [4];
    logic [7:0] w3;
    bit seen;
    words = '{8'h01, 8'h02, 8'h04, 8'h08};
    caps  = '{8'h00, 8'h01, 8'h02, 8'h04};

    clr = 1'b1;
    ld1_data = '0; ld1_valid = 1'b0; cp1_ready = 1'b0;
    ld3_data = '0; ld3_valid = 1'b0; cp3_ready = 1'b0;
    tick();
    tick();
    chk("rst_load_ready", ld1_ready, 1);
    chk("rst_cap_valid", cp1_valid, 0);
    chk("rst_cap_data", cp1_data, 0);
    chk("rst_shift_out", so1, 0);
    chk("rst_shift_en", en1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_load_ready3", ld3_ready, 1);
    clr = 1'b0;
    tick();

    // Loopback A5 then 3C
    xfer1(8'hA5, 8'h00, 1'b0);
    done1();
    xfer1(8'h3C, 8'hA5, 1'b0);

    // Capture backpressure with load_valid held
    ld1_valid = 1'b1;
    ld1_data  = 8'h77;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_cap_data", cp1_data, 8'hA5);
      chk("bp_cap_valid", cp1_valid, 1);
      chk("bp_load_ready", ld1_ready, 0);
    end
    done1();
    xfer1(8'h77, 8'h3C, 1'b0);
    done1();

    // Load pulse during SHIFT must be ignored
    xfer1(8'h5A, 8'h77, 1'b1);
    done1();
    xfer1(8'h96, 8'h5A, 1'b0);
    done1();

    // cap_ready in IDLE
    cp1_ready = 1'b1;
    tick();
    tick();
    cp1_ready = 1'b0;
    chk("idle_cr_busy", busy1, 0);
    chk("idle_cr_cap_valid", cp1_valid, 0);
    chk("idle_cr_ready", ld1_ready, 1);
    chk("idle_cr_cap_data", cp1_data, 8'h5A);

    // Reset mid-SHIFT
    ld1_data  = 8'hC3;
    ld1_valid = 1'b1;
    tick();
    ld1_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    #1;
    chk("mid_rst_load_ready", ld1_ready, 1);
    chk("mid_rst_cap_valid", cp1_valid, 0);
    chk("mid_rst_cap_data", cp1_data, 0);
    chk("mid_rst_shift_out", so1, 0);
    chk("mid_rst_shift_en", en1, 0);
    chk("mid_rst_busy", busy1, 0);
    tick();
    tick();
    clr = 1'b0;
    tick();
    chk("post_rst_ready", ld1_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= cp1_valid;
    end
    chk("post_rst_no_cap", seen, 0);

    // Back-to-back with both handshakes held high
    cp1_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      ld1_data  = words[w];
      ld1_valid = 1'b1;
      chk("b2b_ready_c0", ld1_ready, 1);
      for (int c = 1; c <= 9; c++) begin
        tick();
        if (c == 8) chk("b2b_cap_valid_c8", cp1_valid, 0);
      end
      chk("b2b_cap_valid_c9", cp1_valid, 1);
      chk("b2b_cap_data", cp1_data, caps[w]);
      if (w == 3) ld1_valid = 1'b0;
      tick();
    end
    cp1_ready = 1'b0;
    chk("b2b_end_idle", busy1, 0);
    chk("b2b_chain", chain1, 8'h08);

    // Divider DIV=3: FF then A5
    for (int t = 0; t < 2; t++) begin
      w3 = (t == 0) ? 8'hFF : 8'hA5;
      ld3_data  = w3;
      ld3_valid = 1'b1;
      chk("d3_ready_c0", ld3_ready, 1);
      for (int c = 1; c <= 24; c++) begin
        tick();
        ld3_valid = 1'b0;
        chk("d3_shift_en", en3, (c % 3 == 0) ? 1 : 0);
        chk("d3_shift_out", so3, w3[7-(c-1)/3]);
        chk("d3_cap_valid_early", cp3_valid, 0);
      end
      tick();
      chk("d3_cap_valid_c25", cp3_valid, 1);
      chk("d3_cap_data", cp3_data, (t == 0) ? 8'h00 : 8'hFF);
      cp3_ready = 1'b1;
      tick();
      cp3_ready = 1'b0;
      chk("d3_ready_after", ld3_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
